// File: rtl/axi_pkg.sv
// Shared AXI read-path definitions used by the read arbiter.
//   - arb_state_e : arbiter FSM states
//   - ar_bus_t    : packed AR channel fields (id, addr, len, size, burst,
//                   lock, cache, prot) at the default ID/address widths
//   - AXI_BURST_WRAP, AXI_SIZE_8B : common encodings
package axi_pkg;

    localparam int AXI_ID_WIDTH   = 13;
    localparam int AXI_ADDR_WIDTH = 64;
    localparam int AXI_DATA_WIDTH = 64;

    localparam logic [1:0] AXI_BURST_WRAP = 2'h2;
    localparam logic [2:0] AXI_SIZE_8B    = 3'h3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0]   id;
        logic [AXI_ADDR_WIDTH-1:0] addr;
        logic [7:0]                len;
        logic [2:0]                size;
        logic [1:0]                burst;
        logic                      lock;
        logic [3:0]                cache;
        logic [2:0]                prot;
    } ar_bus_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin pick (purely combinational).
//   req[1:0]   : request vector (bit n = requester n)
//   last_grant : requester that owned the previous burst
//   grant      : index of the chosen requester; only meaningful when req != 0
module rr_arbiter2
    import axi_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant
);

    always_comb begin
        grant = last_grant;
        case (req)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            // contention: hand it to whoever did not have it last time
            2'b11:   grant = ~last_grant;
            default: grant = last_grant;
        endcase
    end

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares one AXI4 read master (AR + R) between requester 0 (instruction
// cache) and requester 1 (data cache). One burst in flight at a time,
// round-robin between the two.
//   clk, reset        : clock, synchronous active-high reset
//   s0_axi_ar* / r*   : requester 0 read channels
//   s1_axi_ar* / r*   : requester 1 read channels
//   m_axi_ar* / r*    : memory-side read master
//   err_rlast         : sticky, rlast seen on a beat count other than arlen+1
// R payload is broadcast to both requesters; only the owner sees rvalid.
//
// state | meaning
// IDLE  | no owner; arbitrate pending arvalids
// ADDR  | owner's AR forwarded to memory, waiting for m_axi_arready
// DATA  | R beats steered to the owner until rlast
module axi_read_arbiter
    import axi_pkg::*;
#(
    // ar_bus_t is built at the package widths, so these should stay at
    // their defaults unless the package is changed to match.
    parameter int ID_WIDTH   = AXI_ID_WIDTH,
    parameter int ADDR_WIDTH = AXI_ADDR_WIDTH,
    parameter int DATA_WIDTH = AXI_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic [ID_WIDTH-1:0]   s0_axi_arid,
    input  logic [ADDR_WIDTH-1:0] s0_axi_araddr,
    input  logic [7:0]            s0_axi_arlen,
    input  logic [2:0]            s0_axi_arsize,
    input  logic [1:0]            s0_axi_arburst,
    input  logic                  s0_axi_arlock,
    input  logic [3:0]            s0_axi_arcache,
    input  logic [2:0]            s0_axi_arprot,
    input  logic                  s0_axi_arvalid,
    output logic                  s0_axi_arready,
    output logic [ID_WIDTH-1:0]   s0_axi_rid,
    output logic [DATA_WIDTH-1:0] s0_axi_rdata,
    output logic [1:0]            s0_axi_rresp,
    output logic                  s0_axi_rlast,
    output logic                  s0_axi_rvalid,
    input  logic                  s0_axi_rready,

    input  logic [ID_WIDTH-1:0]   s1_axi_arid,
    input  logic [ADDR_WIDTH-1:0] s1_axi_araddr,
    input  logic [7:0]            s1_axi_arlen,
    input  logic [2:0]            s1_axi_arsize,
    input  logic [1:0]            s1_axi_arburst,
    input  logic                  s1_axi_arlock,
    input  logic [3:0]            s1_axi_arcache,
    input  logic [2:0]            s1_axi_arprot,
    input  logic                  s1_axi_arvalid,
    output logic                  s1_axi_arready,
    output logic [ID_WIDTH-1:0]   s1_axi_rid,
    output logic [DATA_WIDTH-1:0] s1_axi_rdata,
    output logic [1:0]            s1_axi_rresp,
    output logic                  s1_axi_rlast,
    output logic                  s1_axi_rvalid,
    input  logic                  s1_axi_rready,

    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,

    output logic                  err_rlast
);

    arb_state_e state, state_nx;
    logic       owner, owner_nx;
    logic       last_grant, last_grant_nx;
    logic [7:0] beat_cnt, beat_cnt_nx;
    logic [7:0] len_q, len_q_nx;
    logic       err, err_nx;

    logic       grant;
    logic       own_arvalid;
    logic       own_rready;
    logic       r_beat;
    ar_bus_t    s0_ar, s1_ar, own_ar;

    assign s0_ar = '{id: s0_axi_arid, addr: s0_axi_araddr, len: s0_axi_arlen,
                     size: s0_axi_arsize, burst: s0_axi_arburst, lock: s0_axi_arlock,
                     cache: s0_axi_arcache, prot: s0_axi_arprot};
    assign s1_ar = '{id: s1_axi_arid, addr: s1_axi_araddr, len: s1_axi_arlen,
                     size: s1_axi_arsize, burst: s1_axi_arburst, lock: s1_axi_arlock,
                     cache: s1_axi_arcache, prot: s1_axi_arprot};

    assign own_ar      = owner ? s1_ar : s0_ar;
    assign own_arvalid = owner ? s1_axi_arvalid : s0_axi_arvalid;
    assign own_rready  = owner ? s1_axi_rready  : s0_axi_rready;

    rr_arbiter2 u_rr (
        .req        ({s1_axi_arvalid, s0_axi_arvalid}),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // AR fields follow the owner at all times; only arvalid is qualified.
    assign m_axi_arid    = own_ar.id;
    assign m_axi_araddr  = own_ar.addr;
    assign m_axi_arlen   = own_ar.len;
    assign m_axi_arsize  = own_ar.size;
    assign m_axi_arburst = own_ar.burst;
    assign m_axi_arlock  = own_ar.lock;
    assign m_axi_arcache = own_ar.cache;
    assign m_axi_arprot  = own_ar.prot;

    assign s0_axi_rid   = m_axi_rid;
    assign s0_axi_rdata = m_axi_rdata;
    assign s0_axi_rresp = m_axi_rresp;
    assign s0_axi_rlast = m_axi_rlast;
    assign s1_axi_rid   = m_axi_rid;
    assign s1_axi_rdata = m_axi_rdata;
    assign s1_axi_rresp = m_axi_rresp;
    assign s1_axi_rlast = m_axi_rlast;

    assign r_beat    = m_axi_rvalid & m_axi_rready;
    assign err_rlast = err;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            beat_cnt   <= 8'd0;
            len_q      <= 8'd0;
            err        <= 1'b0;
        end else begin
            state      <= state_nx;
            owner      <= owner_nx;
            last_grant <= last_grant_nx;
            beat_cnt   <= beat_cnt_nx;
            len_q      <= len_q_nx;
            err        <= err_nx;
        end
    end

    always_comb begin
        state_nx       = state;
        owner_nx       = owner;
        last_grant_nx  = last_grant;
        beat_cnt_nx    = beat_cnt;
        len_q_nx       = len_q;
        err_nx         = err;
        m_axi_arvalid  = 1'b0;
        s0_axi_arready = 1'b0;
        s1_axi_arready = 1'b0;
        m_axi_rready   = 1'b0;
        s0_axi_rvalid  = 1'b0;
        s1_axi_rvalid  = 1'b0;

        case (state)
            IDLE: begin
                if (s0_axi_arvalid | s1_axi_arvalid) begin
                    owner_nx    = grant;
                    beat_cnt_nx = 8'd0;
                    state_nx    = ADDR;
                end
            end

            ADDR: begin
                m_axi_arvalid  = own_arvalid;
                s0_axi_arready = ~owner & m_axi_arready;
                s1_axi_arready =  owner & m_axi_arready;
                if (own_arvalid & m_axi_arready) begin
                    len_q_nx = own_ar.len;
                    state_nx = DATA;
                end
            end

            DATA: begin
                m_axi_rready  = own_rready;
                s0_axi_rvalid = ~owner & m_axi_rvalid;
                s1_axi_rvalid =  owner & m_axi_rvalid;
                if (r_beat) begin
                    // 8-bit wrap is intended: arlen=255 ends at beat_cnt=255
                    beat_cnt_nx = beat_cnt + 8'd1;
                    if (m_axi_rlast) begin
                        if (beat_cnt != len_q) begin
                            err_nx = 1'b1;
                        end
                        last_grant_nx = owner;
                        state_nx      = IDLE;
                    end
                end
            end

            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi_read_arbiter.sv
module tb_axi_read_arbiter;

    localparam int IW = 13;
    localparam int AW = 64;
    localparam int DW = 64;

    logic clk, reset;

    logic [IW-1:0] s0_axi_arid, s1_axi_arid, m_axi_arid;
    logic [AW-1:0] s0_axi_araddr, s1_axi_araddr, m_axi_araddr;
    logic [7:0]    s0_axi_arlen, s1_axi_arlen, m_axi_arlen;
    logic [2:0]    s0_axi_arsize, s1_axi_arsize, m_axi_arsize;
    logic [1:0]    s0_axi_arburst, s1_axi_arburst, m_axi_arburst;
    logic          s0_axi_arlock, s1_axi_arlock, m_axi_arlock;
    logic [3:0]    s0_axi_arcache, s1_axi_arcache, m_axi_arcache;
    logic [2:0]    s0_axi_arprot, s1_axi_arprot, m_axi_arprot;
    logic          s0_axi_arvalid, s1_axi_arvalid, m_axi_arvalid;
    logic          s0_axi_arready, s1_axi_arready, m_axi_arready;
    logic [IW-1:0] s0_axi_rid, s1_axi_rid, m_axi_rid;
    logic [DW-1:0] s0_axi_rdata, s1_axi_rdata, m_axi_rdata;
    logic [1:0]    s0_axi_rresp, s1_axi_rresp, m_axi_rresp;
    logic          s0_axi_rlast, s1_axi_rlast, m_axi_rlast;
    logic          s0_axi_rvalid, s1_axi_rvalid, m_axi_rvalid;
    logic          s0_axi_rready, s1_axi_rready, m_axi_rready;
    logic          err_rlast;

    int n_chk  = 0;
    int n_pass = 0;

    axi_read_arbiter dut (
        .clk(clk), .reset(reset),
        .s0_axi_arid(s0_axi_arid), .s0_axi_araddr(s0_axi_araddr), .s0_axi_arlen(s0_axi_arlen),
        .s0_axi_arsize(s0_axi_arsize), .s0_axi_arburst(s0_axi_arburst), .s0_axi_arlock(s0_axi_arlock),
        .s0_axi_arcache(s0_axi_arcache), .s0_axi_arprot(s0_axi_arprot), .s0_axi_arvalid(s0_axi_arvalid),
        .s0_axi_arready(s0_axi_arready), .s0_axi_rid(s0_axi_rid), .s0_axi_rdata(s0_axi_rdata),
        .s0_axi_rresp(s0_axi_rresp), .s0_axi_rlast(s0_axi_rlast), .s0_axi_rvalid(s0_axi_rvalid),
        .s0_axi_rready(s0_axi_rready),
        .s1_axi_arid(s1_axi_arid), .s1_axi_araddr(s1_axi_araddr), .s1_axi_arlen(s1_axi_arlen),
        .s1_axi_arsize(s1_axi_arsize), .s1_axi_arburst(s1_axi_arburst), .s1_axi_arlock(s1_axi_arlock),
        .s1_axi_arcache(s1_axi_arcache), .s1_axi_arprot(s1_axi_arprot), .s1_axi_arvalid(s1_axi_arvalid),
        .s1_axi_arready(s1_axi_arready), .s1_axi_rid(s1_axi_rid), .s1_axi_rdata(s1_axi_rdata),
        .s1_axi_rresp(s1_axi_rresp), .s1_axi_rlast(s1_axi_rlast), .s1_axi_rvalid(s1_axi_rvalid),
        .s1_axi_rready(s1_axi_rready),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
        .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready), .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata),
        .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready),
        .err_rlast(err_rlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // inputs change and outputs are sampled around the falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_req(input int p, input logic v, input logic [63:0] addr,
                           input logic [7:0] len, input logic [12:0] id);
        if (p == 0) begin
            s0_axi_arvalid = v; s0_axi_araddr = addr; s0_axi_arlen = len; s0_axi_arid = id;
            s0_axi_arsize = 3'h3; s0_axi_arburst = 2'h1; s0_axi_arcache = 4'h3; s0_axi_arprot = 3'h4;
            s0_axi_arlock = 1'b0;
        end else begin
            s1_axi_arvalid = v; s1_axi_araddr = addr; s1_axi_arlen = len; s1_axi_arid = id;
            s1_axi_arsize = 3'h2; s1_axi_arburst = 2'h2; s1_axi_arcache = 4'hf; s1_axi_arprot = 3'h2;
            s1_axi_arlock = 1'b1;
        end
    endtask

    // DUT is expected to be in ADDR for requester p; memory stalls wait_cyc cycles
    task automatic accept(input int p, input logic [63:0] addr, input logic [7:0] len,
                          input logic [12:0] id, input int wait_cyc);
        for (int w = 0; w < wait_cyc; w++) begin
            #1;
            check("arvalid_stall", 64'(m_axi_arvalid), 64'd1);
            check("arready_stall", 64'(p == 0 ? s0_axi_arready : s1_axi_arready), 64'd0);
            tick();
        end
        m_axi_arready = 1'b1;
        #1;
        check("m_arvalid", 64'(m_axi_arvalid), 64'd1);
        check("m_araddr", m_axi_araddr, addr);
        check("m_arlen", 64'(m_axi_arlen), 64'(len));
        check("m_arid", 64'(m_axi_arid), 64'(id));
        check("m_arburst", 64'(m_axi_arburst), (p == 0) ? 64'h1 : 64'h2);
        check("m_arlock", 64'(m_axi_arlock), (p == 0) ? 64'h0 : 64'h1);
        check("own_arready", 64'(p == 0 ? s0_axi_arready : s1_axi_arready), 64'd1);
        check("oth_arready", 64'(p == 0 ? s1_axi_arready : s0_axi_arready), 64'd0);
        tick();
        set_req(p, 1'b0, addr, len, id);
        m_axi_arready = 1'b0;
    endtask

    // DUT is in DATA for requester p; deliver up to nbeats, rlast on beat last_at
    task automatic burst(input int p, input int nbeats, input int last_at);
        logic [63:0] d;
        s0_axi_rready = (p == 0);
        s1_axi_rready = (p == 1);
        for (int i = 0; i < nbeats; i++) begin
            d = {32'hD0D0_0000 + 32'(p), 32'(i)};
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = d;
            m_axi_rid    = 13'(p + 3);
            m_axi_rresp  = 2'b00;
            m_axi_rlast  = (i == last_at);
            #1;
            check("own_rvalid", 64'(p == 0 ? s0_axi_rvalid : s1_axi_rvalid), 64'd1);
            check("oth_rvalid", 64'(p == 0 ? s1_axi_rvalid : s0_axi_rvalid), 64'd0);
            check("m_rready", 64'(m_axi_rready), 64'd1);
            check("own_rdata", (p == 0) ? s0_axi_rdata : s1_axi_rdata, d);
            check("oth_rdata", (p == 0) ? s1_axi_rdata : s0_axi_rdata, d);
            tick();
            if (i == last_at) break;
        end
        m_axi_rvalid  = 1'b0;
        m_axi_rlast   = 1'b0;
        s0_axi_rready = 1'b0;
        s1_axi_rready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        #1;
        check({tag, "_m_arvalid"}, 64'(m_axi_arvalid), 64'd0);
        check({tag, "_m_rready"}, 64'(m_axi_rready), 64'd0);
        check({tag, "_s0_rvalid"}, 64'(s0_axi_rvalid), 64'd0);
        check({tag, "_s1_rvalid"}, 64'(s1_axi_rvalid), 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        set_req(0, 1'b0, 64'h0, 8'd0, 13'd0);
        set_req(1, 1'b0, 64'h0, 8'd0, 13'd0);
        s0_axi_rready = 1'b0; s1_axi_rready = 1'b0;
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
        m_axi_rid = '0; m_axi_rdata = '0; m_axi_rresp = '0;
        tick();
        tick();

        // reset state
        check_idle("rst");
        check("rst_s0_arready", 64'(s0_axi_arready), 64'd0);
        check("rst_s1_arready", 64'(s1_axi_arready), 64'd0);
        check("rst_err", 64'(err_rlast), 64'd0);
        reset = 1'b0;
        tick();

        // stray R beat in IDLE is never accepted or delivered
        m_axi_rvalid = 1'b1;
        s0_axi_rready = 1'b1;
        check_idle("stray");
        m_axi_rvalid = 1'b0;
        s0_axi_rready = 1'b0;

        // 1: s0 alone, memory arready after 2 cycles, 8 beats
        set_req(0, 1'b1, 64'h1000, 8'd7, 13'h05);
        #1;
        check("t1_grant_latency", 64'(m_axi_arvalid), 64'd0);
        tick();
        accept(0, 64'h1000, 8'd7, 13'h05, 2);
        burst(0, 8, 7);
        check_idle("t1_end");
        check("t1_err", 64'(err_rlast), 64'd0);

        // 2: simultaneous requests after reset, s0 first then s1
        do_reset();
        set_req(0, 1'b1, 64'h2000, 8'd1, 13'h10);
        set_req(1, 1'b1, 64'h3000, 8'd1, 13'h11);
        tick();
        accept(0, 64'h2000, 8'd1, 13'h10, 0);
        burst(0, 2, 1);
        #1;
        check("t2_no_b2b_ar", 64'(m_axi_arvalid), 64'd0);
        tick();
        accept(1, 64'h3000, 8'd1, 13'h11, 0);
        burst(1, 2, 1);

        // 3: s1 waits during s0 burst, wins over s0's immediate re-request
        set_req(0, 1'b1, 64'h4000, 8'd3, 13'h20);
        tick();
        accept(0, 64'h4000, 8'd3, 13'h20, 0);
        set_req(1, 1'b1, 64'h5000, 8'd0, 13'h21);
        burst(0, 4, 3);
        set_req(0, 1'b1, 64'h6000, 8'd0, 13'h22);
        tick();
        accept(1, 64'h5000, 8'd0, 13'h21, 0);
        burst(1, 1, 0);
        tick();
        accept(0, 64'h6000, 8'd0, 13'h22, 0);
        burst(0, 1, 0);

        // 4: owner drops rready for 3 cycles mid-burst; non-owner rready high
        set_req(0, 1'b1, 64'h7000, 8'd3, 13'h30);
        tick();
        accept(0, 64'h7000, 8'd3, 13'h30, 0);
        s1_axi_rready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = 64'(i);
            m_axi_rlast  = (i == 3);
            s0_axi_rready = 1'b1;
            if (i == 2) begin
                s0_axi_rready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    #1;
                    check("t4_stall_m_rready", 64'(m_axi_rready), 64'd0);
                    check("t4_stall_rvalid", 64'(s0_axi_rvalid), 64'd1);
                    check("t4_stall_beat_cnt", 64'(dut.beat_cnt), 64'd2);
                    tick();
                end
                s0_axi_rready = 1'b1;
            end
            #1;
            check("t4_m_rready", 64'(m_axi_rready), 64'd1);
            check("t4_rdata", s0_axi_rdata, 64'(i));
            tick();
        end
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
        s0_axi_rready = 1'b0; s1_axi_rready = 1'b0;
        check_idle("t4_end");
        check("t4_err", 64'(err_rlast), 64'd0);

        // 5: arlen=7 but rlast on beat 4 -> sticky error, FSM back to IDLE
        set_req(0, 1'b1, 64'h8000, 8'd7, 13'h40);
        tick();
        accept(0, 64'h8000, 8'd7, 13'h40, 0);
        burst(0, 4, 3);
        check_idle("t5_end");
        check("t5_err", 64'(err_rlast), 64'd1);
        set_req(1, 1'b1, 64'h9000, 8'd0, 13'h41);
        tick();
        accept(1, 64'h9000, 8'd0, 13'h41, 0);
        burst(1, 1, 0);
        #1;
        check("t5_err_sticky", 64'(err_rlast), 64'd1);

        // 6: reset in DATA after beat 3
        set_req(0, 1'b1, 64'hA000, 8'd7, 13'h50);
        tick();
        accept(0, 64'hA000, 8'd7, 13'h50, 0);
        burst(0, 3, 99);
        m_axi_rvalid = 1'b1;
        s0_axi_rready = 1'b1;
        reset = 1'b1;
        tick();
        check_idle("t6_rst");
        check("t6_err", 64'(err_rlast), 64'd0);
        reset = 1'b0;
        tick();
        check_idle("t6_after");
        m_axi_rvalid = 1'b0;
        s0_axi_rready = 1'b0;

        // 7: arlen=255, 256 beats; 8-bit counter wraps cleanly, no error
        set_req(1, 1'b1, 64'hB000, 8'd255, 13'h60);
        tick();
        accept(1, 64'hB000, 8'd255, 13'h60, 0);
        burst(1, 256, 255);
        check_idle("t7_end");
        check("t7_err", 64'(err_rlast), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
